rs_station_param: RTL and testbench

- Parametrised Tomasulo reservation station: holds up to DEPTH issued instructions, snoops the CDB for pending operands and dispatches ready entries to one functional unit.
- An entry stays allocated until its own result tag appears on the CDB.
- Sits between the instruction queue / selector and an add/sub or mul/div unit.
- One instance per FU class.

---
 rtl/tomasulo_pkg.sv | 24 ++
 rtl/rs_station_param_if.sv | 51 +++++
 rtl/rs_entry.sv | 83 ++++++++
 rtl/rs_station_param.sv | 138 +++++++++++++
 tb/tb_rs_station_param.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
//==============================================================================
// Module : tomasulo_pkg
// Shared opcodes, tag constants and reservation-station entry state.
// Rev    : 1.0 initial release
//==============================================================================
`default_nettype none

package tomasulo_pkg;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;

    localparam int TAG_NONE = 0;

    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2,
        RS_EXEC  = 2'd3
    } rs_state_t;
endpackage

`default_nettype wire

// File: rtl/rs_station_param_if.sv
//==============================================================================
// Module : rs_station_param_if
// Issue, CDB, dispatch and status signals of one reservation station.
// Rev    : 1.0 initial release
//==============================================================================
`default_nettype none

interface rs_station_param_if #(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [DATA_W-1:0] issue_vj;
    logic [DATA_W-1:0] issue_vk;
    logic [TAG_W-1:0]  issue_qj;
    logic [TAG_W-1:0]  issue_qk;
    logic [TAG_W-1:0]  issue_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [DATA_W-1:0] disp_vj;
    logic [DATA_W-1:0] disp_vk;
    logic [TAG_W-1:0]  disp_tag;
    logic [CNT_W-1:0]  count;
    logic              full;

    modport master (
        output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
               cdb_valid, cdb_tag, cdb_value, disp_ready,
        input  issue_ready, issue_tag, disp_valid, disp_op, disp_vj, disp_vk,
               disp_tag, count, full
    );

    modport slave (
        input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
               cdb_valid, cdb_tag, cdb_value, disp_ready,
        output issue_ready, issue_tag, disp_valid, disp_op, disp_vj, disp_vk,
               disp_tag, count, full
    );
endinterface

`default_nettype wire

// File: rtl/rs_entry.sv
//==============================================================================
// Module : rs_entry
// One reservation-station slot: state, operand capture and CDB snoop.
// Rev    : 1.0 initial release
//==============================================================================
`default_nettype none

module rs_entry
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int TAG_W  = 4,
    parameter int MY_TAG = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alloc,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              dispatch,
    output rs_state_t         state,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk,
    output logic              freeing
);
    logic [TAG_W-1:0] qj, qk, next_qj, next_qk;
    logic             cdb_live, bypass_j, bypass_k, snoop_j, snoop_k;

    assign cdb_live = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
    assign bypass_j = cdb_live && (issue_qj == cdb_tag);
    assign bypass_k = cdb_live && (issue_qk == cdb_tag);
    assign snoop_j  = cdb_live && (state == RS_WAIT) && (qj == cdb_tag);
    assign snoop_k  = cdb_live && (state == RS_WAIT) && (qk == cdb_tag);
    assign freeing  = (state == RS_EXEC) && cdb_valid && (cdb_tag == TAG_W'(MY_TAG));

    always_comb begin
        next_qj = snoop_j ? '0 : qj;
        next_qk = snoop_k ? '0 : qk;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RS_FREE;
            op    <= '0;
            vj    <= '0;
            vk    <= '0;
            qj    <= '0;
            qk    <= '0;
        end else begin
            case (state)
                RS_FREE: if (alloc) begin
                    op <= issue_op;
                    vj <= bypass_j ? cdb_value : issue_vj;
                    vk <= bypass_k ? cdb_value : issue_vk;
                    qj <= bypass_j ? '0 : issue_qj;
                    qk <= bypass_k ? '0 : issue_qk;
                    state <= (((bypass_j ? '0 : issue_qj) | (bypass_k ? '0 : issue_qk)) == '0)
                             ? RS_READY : RS_WAIT;
                end
                RS_WAIT: begin
                    if (snoop_j) vj <= cdb_value;
                    if (snoop_k) vk <= cdb_value;
                    qj <= next_qj;
                    qk <= next_qk;
                    if ((next_qj | next_qk) == '0) state <= RS_READY;
                end
                RS_READY: if (dispatch) state <= RS_EXEC;
                RS_EXEC:  if (freeing)  state <= RS_FREE;
                default:  state <= RS_FREE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/rs_station_param.sv
//==============================================================================
// Module : rs_station_param
// Reservation station top: allocation, dispatch selection, occupancy count.
// Optional RS_AGE_ORDER_EN: dispatch oldest READY entry instead of lowest index.
// Rev    : 1.0 initial release
//==============================================================================
`default_nettype none

module rs_station_param
    import tomasulo_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int DATA_W   = 8,
    parameter int OP_W     = 4,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    rs_station_param_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_state_t         st   [DEPTH];
    logic [OP_W-1:0]   e_op [DEPTH];
    logic [DATA_W-1:0] e_vj [DEPTH];
    logic [DATA_W-1:0] e_vk [DEPTH];
    logic [DEPTH-1:0]  alloc, dispatch, freeing;
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  free_idx, sel_idx;
    logic              sel_found, issue_fire;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            rs_entry #(
                .DATA_W(DATA_W), .OP_W(OP_W), .TAG_W(TAG_W), .MY_TAG(TAG_BASE + i)
            ) u_entry (
                .clock(clock), .reset_n(reset_n), .alloc(alloc[i]),
                .issue_op(bus.issue_op), .issue_vj(bus.issue_vj), .issue_vk(bus.issue_vk),
                .issue_qj(bus.issue_qj), .issue_qk(bus.issue_qk),
                .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_value(bus.cdb_value),
                .dispatch(dispatch[i]), .state(st[i]), .op(e_op[i]),
                .vj(e_vj[i]), .vk(e_vk[i]), .freeing(freeing[i])
            );
            assign alloc[i]    = issue_fire && (free_idx == IDX_W'(i));
            assign dispatch[i] = sel_found && bus.disp_ready && (sel_idx == IDX_W'(i));
        end
    endgenerate

    // Descending scan so the lowest-index FREE entry wins.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (st[i] == RS_FREE) free_idx = IDX_W'(i);
    end

`ifdef RS_AGE_ORDER_EN
    logic [IDX_W-1:0] rank [DEPTH];
    logic [IDX_W-1:0] free_rank, hold_idx;
    logic             free_hit, hold_valid;

    // A presented-but-stalled entry is held so an older wake-up cannot displace it.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        if (hold_valid) begin
            sel_found = 1'b1;
            sel_idx   = hold_idx;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (st[i] == RS_READY && (!sel_found || rank[i] < rank[sel_idx])) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
        end
    end

    always_comb begin
        free_hit  = 1'b0;
        free_rank = '0;
        for (int i = 0; i < DEPTH; i++)
            if (freeing[i]) begin
                free_hit  = 1'b1;
                free_rank = rank[i];
            end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) rank[i] <= '0;
            hold_valid <= 1'b0;
            hold_idx   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc[i])
                    rank[i] <= IDX_W'(count_q - CNT_W'(free_hit));
                else if (free_hit && st[i] != RS_FREE && rank[i] > free_rank)
                    rank[i] <= rank[i] - 1'b1;
            end
            hold_valid <= sel_found && !bus.disp_ready;
            hold_idx   <= sel_idx;
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (st[i] == RS_READY) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
    end
`endif

    assign issue_fire      = bus.issue_valid && bus.issue_ready;
    assign bus.issue_ready = !bus.full;
    assign bus.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign bus.disp_valid  = sel_found;
    assign bus.disp_op     = sel_found ? e_op[sel_idx] : '0;
    assign bus.disp_vj     = sel_found ? e_vj[sel_idx] : '0;
    assign bus.disp_vk     = sel_found ? e_vk[sel_idx] : '0;
    assign bus.disp_tag    = sel_found ? TAG_W'(TAG_BASE) + TAG_W'(sel_idx) : '0;
    assign bus.count       = count_q;
    assign bus.full        = (count_q == CNT_W'(DEPTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else if (issue_fire && !(|freeing))
            count_q <= count_q + 1'b1;
        else if (!issue_fire && (|freeing))
            count_q <= count_q - 1'b1;
    end
endmodule

`default_nettype wire

// File: tb/tb_rs_station_param.sv
//==============================================================================
// Module : tb_rs_station_param
// Directed bench for rs_station_param with a cycle-level reference model.
// Rev    : 1.0 initial release
//==============================================================================
`default_nettype none

module tb_rs_station_param;
    import tomasulo_pkg::*;

    localparam int D  = 3;
    localparam int TB = 1;
    localparam int MS_FREE = 0, MS_WAIT = 1, MS_READY = 2, MS_EXEC = 3;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rs_station_param_if #(.DEPTH(D), .DATA_W(8), .OP_W(4), .TAG_W(4)) bus ();

    rs_station_param #(.DEPTH(D), .DATA_W(8), .OP_W(4), .TAG_W(4), .TAG_BASE(TB)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot contents plus allocation sequence numbers for age.
    int         m_st  [D];
    logic [3:0] m_op  [D], m_qj [D], m_qk [D];
    logic [7:0] m_vj  [D], m_vk [D];
    int         m_seq [D];
    int         next_seq, m_hold_idx;
    bit         m_hold;
    int         u_sel, u_fi, cs;
    bit         u_acc;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < D; i++) if (m_st[i] != MS_FREE) n++;
        return n;
    endfunction

    function automatic int m_free_idx();
        for (int i = 0; i < D; i++) if (m_st[i] == MS_FREE) return i;
        return -1;
    endfunction

    function automatic int m_sel();
        int best = -1;
`ifdef RS_AGE_ORDER_EN
        if (m_hold) return m_hold_idx;
        for (int i = 0; i < D; i++)
            if (m_st[i] == MS_READY && (best < 0 || m_seq[i] < m_seq[best])) best = i;
`else
        for (int i = 0; i < D; i++)
            if (m_st[i] == MS_READY && best < 0) best = i;
`endif
        return best;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < D; i++) begin
                m_st[i] = MS_FREE; m_qj[i] = 0; m_qk[i] = 0;
                m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_seq[i] = 0;
            end
            next_seq = 0; m_hold = 0; m_hold_idx = 0;
        end else begin
            u_sel = m_sel();
            u_fi  = m_free_idx();
            u_acc = bus.issue_valid && (m_count() < D);
            for (int i = 0; i < D; i++)
                if (m_st[i] == MS_EXEC && bus.cdb_valid && bus.cdb_tag == 4'(TB + i))
                    m_st[i] = MS_FREE;
            if (u_sel >= 0 && bus.disp_ready) m_st[u_sel] = MS_EXEC;
            for (int i = 0; i < D; i++)
                if (m_st[i] == MS_WAIT && bus.cdb_valid && bus.cdb_tag != 0) begin
                    if (m_qj[i] == bus.cdb_tag) begin m_vj[i] = bus.cdb_value; m_qj[i] = 0; end
                    if (m_qk[i] == bus.cdb_tag) begin m_vk[i] = bus.cdb_value; m_qk[i] = 0; end
                    if (m_qj[i] == 0 && m_qk[i] == 0) m_st[i] = MS_READY;
                end
            if (u_acc) begin
                m_op[u_fi] = bus.issue_op;
                m_vj[u_fi] = bus.issue_vj; m_qj[u_fi] = bus.issue_qj;
                m_vk[u_fi] = bus.issue_vk; m_qk[u_fi] = bus.issue_qk;
                if (bus.cdb_valid && bus.cdb_tag != 0 && bus.issue_qj == bus.cdb_tag) begin
                    m_vj[u_fi] = bus.cdb_value; m_qj[u_fi] = 0;
                end
                if (bus.cdb_valid && bus.cdb_tag != 0 && bus.issue_qk == bus.cdb_tag) begin
                    m_vk[u_fi] = bus.cdb_value; m_qk[u_fi] = 0;
                end
                m_st[u_fi]  = (m_qj[u_fi] == 0 && m_qk[u_fi] == 0) ? MS_READY : MS_WAIT;
                m_seq[u_fi] = next_seq++;
            end
            m_hold     = (u_sel >= 0) && !bus.disp_ready;
            m_hold_idx = u_sel;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            cs = m_sel();
            check("issue_ready", 32'(bus.issue_ready), 32'(m_count() < D));
            if (m_count() < D) check("issue_tag", 32'(bus.issue_tag), 32'(TB + m_free_idx()));
            check("count", 32'(bus.count), 32'(m_count()));
            check("full", 32'(bus.full), 32'(m_count() == D));
            check("disp_valid", 32'(bus.disp_valid), 32'(cs >= 0));
            if (cs >= 0)
                check("disp_bundle", {8'h0, bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag},
                      {8'h0, m_op[cs], m_vj[cs], m_vk[cs], 4'(TB + cs)});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_op = 0; bus.issue_vj = 0; bus.issue_vk = 0;
        bus.issue_qj = 0; bus.issue_qk = 0;
        bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] vj, input logic [7:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk);
        bus.issue_valid = 1; bus.issue_op = op; bus.issue_vj = vj; bus.issue_vk = vk;
        bus.issue_qj = qj; bus.issue_qk = qk;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [7:0] val);
        bus.cdb_valid = 1; bus.cdb_tag = tag; bus.cdb_value = val;
    endtask

    initial begin
        idle();
        bus.disp_ready = 0;
        #1 cmp_en = 1;
        #2;
        check("rst_count", 32'(bus.count), 0);
        check("rst_issue_tag", 32'(bus.issue_tag), 1);
        check("rst_issue_ready", 32'(bus.issue_ready), 1);
        check("rst_disp", {bus.disp_valid, bus.disp_op, bus.disp_vj, bus.disp_vk, bus.disp_tag}, 0);
        tick(); tick(); reset_n = 1;

        // Ready-operand issue, dispatch, completion
        tick(); issue(OP_ADD, 8'd2, 8'd4, 0, 0); #1 check("t1_issue_tag", 32'(bus.issue_tag), 1);
        tick(); idle(); bus.disp_ready = 1;
        #1 check("t1_disp", {bus.disp_valid, bus.disp_vj, bus.disp_vk, bus.disp_tag}, {1'b1, 8'd2, 8'd4, 4'd1});
        tick(); bus.disp_ready = 0; cdb(1, 8'd6);
        #1 check("t1_exec_hidden", 32'(bus.disp_valid), 0);
        check("t1_count_exec", 32'(bus.count), 1);
        tick(); idle(); #1 check("t1_count_done", 32'(bus.count), 0);

        // Wake-up from an out-of-range producer tag
        tick(); issue(OP_SUB, 8'd0, 8'd3, 4'd5, 0);
        tick(); idle(); #1 check("t2_wait", 32'(bus.disp_valid), 0);
        tick(); cdb(5, 8'd9); #1 check("t2_wait_cdb", 32'(bus.disp_valid), 0);
        tick(); idle();
        #1 check("t2_disp", {bus.disp_valid, bus.disp_op, bus.disp_vj, bus.disp_vk}, {1'b1, OP_SUB, 8'd9, 8'd3});
        bus.disp_ready = 1;
        tick(); bus.disp_ready = 0; cdb(1, 8'd6);
        tick(); idle();

        // Issue/CDB bypass
        tick(); issue(OP_ADD, 8'd0, 8'd1, 4'd7, 0); cdb(7, 8'h2A);
        tick(); idle(); #1 check("t3_bypass", {bus.disp_valid, bus.disp_vj}, {1'b1, 8'h2A});
        bus.disp_ready = 1;
        tick(); bus.disp_ready = 0; cdb(1, 8'd0);
        tick(); idle();

        // Fill, blocked issue, free, no same-cycle reuse
        tick(); issue(OP_MUL, 8'd1, 8'd1, 0, 0);
        tick(); issue(OP_MUL, 8'd2, 8'd2, 0, 0);
        tick(); issue(OP_MUL, 8'd3, 8'd3, 0, 0);
        tick(); issue(OP_DIV, 8'd9, 8'd9, 0, 0);
        #1 check("t4_full", {bus.full, bus.issue_ready, bus.count}, {1'b1, 1'b0, 2'd3});
        tick(); idle(); #1 check("t4_ignored", 32'(bus.count), 3);
        bus.disp_ready = 1;
        tick(); tick(); bus.disp_ready = 0; cdb(2, 8'd0);
        #1 check("t4_no_reuse", 32'(bus.issue_ready), 0);
        tick(); idle();
        #1 check("t4_freed", {bus.issue_ready, bus.issue_tag, bus.count}, {1'b1, 4'd2, 2'd2});
        tick(); cdb(3, 8'd0);
        tick(); idle(); #1 check("t4_ready_not_freed", 32'(bus.count), 2);
        bus.disp_ready = 1;
        tick(); bus.disp_ready = 0;
        tick(); #1 check("t5_two_exec", {bus.count, bus.disp_valid}, {2'd2, 1'b0});

        // Asynchronous reset mid-cycle with two EXEC entries
        #1 reset_n = 0;
        #1 check("t5_async", {bus.count, bus.full, bus.disp_valid, bus.issue_ready, bus.issue_tag},
                 {2'd0, 1'b0, 1'b0, 1'b1, 4'd1});
        tick(); reset_n = 1;
        tick(); cdb(1, 8'd5);
        tick(); idle(); #1 check("t5_stale_cdb", {bus.count, bus.disp_valid}, {2'd0, 1'b0});

        // Age ordering versus lowest-index selection
        tick(); issue(OP_ADD, 8'h11, 0, 0, 0);
        tick(); issue(OP_ADD, 8'h22, 0, 0, 0); bus.disp_ready = 1;
        tick(); idle();
        tick(); bus.disp_ready = 0; issue(OP_ADD, 8'h33, 0, 0, 0);
        #1 check("t6_tag3", 32'(bus.issue_tag), 3);
        tick(); idle(); cdb(1, 8'd0);
        tick(); idle(); issue(OP_ADD, 8'h44, 0, 0, 0);
        #1 check("t6_tag1", 32'(bus.issue_tag), 1);
        tick(); idle();
`ifdef RS_AGE_ORDER_EN
        #1 check("t6_first", {bus.disp_tag, bus.disp_vj}, {4'd3, 8'h33});
`else
        #1 check("t6_first", {bus.disp_tag, bus.disp_vj}, {4'd1, 8'h44});
`endif
        bus.disp_ready = 1;
        tick();
`ifdef RS_AGE_ORDER_EN
        #1 check("t6_second", {bus.disp_tag, bus.disp_vj}, {4'd1, 8'h44});
`else
        #1 check("t6_second", {bus.disp_tag, bus.disp_vj}, {4'd3, 8'h33});
`endif
        tick(); bus.disp_ready = 0;
        tick(); tick();
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
